// File: rtl/storage_pkg.sv
// Shared types for the storage read responder: FSM states, master indices, counter width.
// Latency: n/a (declarations only). Backpressure: n/a.
// Consumers import storage_pkg::*.
package storage_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } rd_state_e;

    localparam logic MST_FETCH = 1'b0;
    localparam logic MST_EXEC  = 1'b1;

    // Wide enough to count up to the largest supported MEM_LAT (4).
    localparam int LAT_CNT_W = 3;

endpackage

// File: rtl/storage_read_responder_arb.sv
// read_grant_arb: picks which master is granted (STORAGE_READ_RR_EN selects round-robin, else exec-priority).
// Latency: combinational. Backpressure: none; the caller only samples the grant when en is high.
// ptr is the index granted last; round-robin hands a tie to the other master.
module read_grant_arb
    import storage_pkg::*;
(
    input  logic req_fetch,
    input  logic req_exec,
    input  logic ptr,
    input  logic en,
    output logic gnt
);

`ifdef STORAGE_READ_RR_EN
    always_comb begin
        gnt = MST_FETCH;
        if (en) begin
            if (req_fetch && req_exec)
                gnt = ~ptr;
            else if (req_exec)
                gnt = MST_EXEC;
            else
                gnt = MST_FETCH;
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ptr ^ req_fetch;
    assign gnt = (en && req_exec) ? MST_EXEC : MST_FETCH;
`endif

endmodule

// File: rtl/storage_read_responder.sv
// Arbitrates two read masters onto one fixed-latency memory port (macro STORAGE_READ_RR_EN: round-robin ties).
// Latency: request edge to readFin is MEM_LAT+2 cycles; back-to-back grants issue straight from RESP.
// Backpressure: a master holds readEn until its readFin; the memory side never stalls.
module storage_read_responder
    import storage_pkg::*;
#(
    parameter int ADDR_W  = 28,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_readEn,
    input  logic [ADDR_W-1:0] fetch_readAddr,
    output logic [31:0]       fetch_readData,
    output logic              fetch_readFin,
    input  logic              exec_readEn,
    input  logic [ADDR_W-1:0] exec_readAddr,
    output logic [31:0]       exec_readData,
    output logic              exec_readFin,
    output logic              mem_rdEn,
    output logic [ADDR_W-3:0] mem_rdAddr,
    input  logic [31:0]       mem_rdData,
    output logic              readIdxMaster,
    output logic              busy
);

    rd_state_e            state;
    logic [LAT_CNT_W-1:0] lat_cnt;
    logic                 rr_ptr;
    logic                 req_fetch;
    logic                 req_exec;
    logic                 arb_en;
    logic                 gnt;
    logic                 unused_addr_lsb;

    assign unused_addr_lsb = ^{fetch_readAddr[1:0], exec_readAddr[1:0]};

    // The master finishing in RESP must not win again in the same cycle.
    assign req_fetch = fetch_readEn && !(state == RESP && readIdxMaster == MST_FETCH);
    assign req_exec  = exec_readEn  && !(state == RESP && readIdxMaster == MST_EXEC);
    assign arb_en    = (state == IDLE) || (state == RESP);
    assign busy      = (state != IDLE);

    read_grant_arb u_arb (
        .req_fetch (req_fetch),
        .req_exec  (req_exec),
        .ptr       (rr_ptr),
        .en        (arb_en),
        .gnt       (gnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            lat_cnt        <= '0;
            rr_ptr         <= MST_FETCH;
            readIdxMaster  <= MST_FETCH;
            mem_rdEn       <= 1'b0;
            mem_rdAddr     <= '0;
            fetch_readFin  <= 1'b0;
            exec_readFin   <= 1'b0;
            fetch_readData <= '0;
            exec_readData  <= '0;
        end else begin
            mem_rdEn      <= 1'b0;
            fetch_readFin <= 1'b0;
            exec_readFin  <= 1'b0;
            case (state)
                IDLE, RESP: begin
                    if (req_fetch || req_exec) begin
                        state         <= ISSUE;
                        readIdxMaster <= gnt;
                        rr_ptr        <= gnt;
                        mem_rdEn      <= 1'b1;
                        mem_rdAddr    <= (gnt == MST_EXEC) ? exec_readAddr[ADDR_W-1:2]
                                                           : fetch_readAddr[ADDR_W-1:2];
                    end else begin
                        state <= IDLE;
                    end
                end
                ISSUE: begin
                    state   <= WAIT;
                    lat_cnt <= LAT_CNT_W'(1);
                end
                WAIT: begin
                    // Memory data is valid on the MEM_LAT-th cycle after the strobe.
                    if (lat_cnt == LAT_CNT_W'(MEM_LAT)) begin
                        state   <= RESP;
                        lat_cnt <= '0;
                        if (readIdxMaster == MST_EXEC) begin
                            exec_readData <= mem_rdData;
                            exec_readFin  <= 1'b1;
                        end else begin
                            fetch_readData <= mem_rdData;
                            fetch_readFin  <= 1'b1;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + LAT_CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
